// File: rtl/systolic_array_gradient_cell.sv
// systolic_array_gradient_cell
// Streaming horizontal-gradient cell. Takes one 3-pixel image column per
// accepted beat (rows r-1, r, r+1), forms a column sum according to the
// per-row kernel (central difference or Sobel-x), keeps a two-column
// history and emits G = S[c] - S[c-2], centred on column c-1.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_top/in_mid/in_bot    column pixels (unsigned, DATA_W)
//   in_val/in_rdy           input handshake (in_rdy is combinational)
//   new_row                 beat is column 0 of a new row
//   mode                    0 = central difference, 1 = Sobel-x (new_row beats)
//   out_grad/out_val        registered signed gradient and its valid
//   out_rdy                 consumer ready
//   ovf                     sticky: a row ran past MAX_COLS columns
//   out_col                 centre column index of out_grad (optional)
//
// Optional feature macro: GRADIENT_CELL_COLIDX_EN adds the out_col port.

module systolic_array_gradient_cell #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_COLS = 640,
  localparam int unsigned OUT_W   = DATA_W + 3,
  localparam int unsigned CNT_W   = $clog2(MAX_COLS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       in_top,
  input  logic [DATA_W-1:0]       in_mid,
  input  logic [DATA_W-1:0]       in_bot,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic                    new_row,
  input  logic                    mode,
  output logic signed [OUT_W-1:0] out_grad,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic                    ovf
`ifdef GRADIENT_CELL_COLIDX_EN
  ,
  output logic [CNT_W-1:0]        out_col
`endif
);

  typedef enum logic [1:0] {IDLE, FILL1, FILL2, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   col_cnt;
  logic [OUT_W-1:0]   h1;
  logic [OUT_W-1:0]   h2;
  logic               mode_q;

  logic               accept;
  logic               restart;
  logic               use_sobel;
  logic [OUT_W-1:0]   col_sum;
  logic [OUT_W-1:0]   grad;
  logic               cnt_at_max;
  logic [CNT_W-1:0]   cnt_inc;

  // Single output register: a slot opens when it is empty or being drained.
  assign in_rdy = !out_val || out_rdy;
  assign accept = in_val && in_rdy;

  // Column sum, next-count and gradient datapath.
  always_comb begin
    restart    = new_row || (state == IDLE);
    // A new_row beat is summed with the incoming mode, not the stale one.
    use_sobel  = new_row ? mode : mode_q;
    col_sum    = OUT_W'(in_mid);
    if (use_sobel) begin
      col_sum = OUT_W'(in_top) + (OUT_W'(in_mid) << 1) + OUT_W'(in_bot);
    end
    // Sums are non-negative and below 2^(OUT_W-1), so modular subtraction
    // is exactly the two's-complement difference.
    grad       = col_sum - h2;
    cnt_at_max = (col_cnt == CNT_W'(MAX_COLS - 1));
    cnt_inc    = cnt_at_max ? col_cnt : col_cnt + CNT_W'(1);
  end

  // Row FSM, history shift register and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      col_cnt  <= '0;
      h1       <= '0;
      h2       <= '0;
      mode_q   <= 1'b0;
      out_grad <= '0;
      out_val  <= 1'b0;
      ovf      <= 1'b0;
`ifdef GRADIENT_CELL_COLIDX_EN
      out_col  <= '0;
`endif
    end else begin
      if (out_val && out_rdy) begin
        out_val <= 1'b0;
      end
      if (accept) begin
        if (restart) begin
          // Column 0 of a row: only seeds the history, never produces output.
          h2      <= '0;
          h1      <= col_sum;
          col_cnt <= '0;
          state   <= FILL1;
          if (new_row) begin
            mode_q <= mode;
          end
        end else begin
          h2      <= h1;
          h1      <= col_sum;
          col_cnt <= cnt_inc;
          if (cnt_at_max) begin
            ovf <= 1'b1;
          end
          case (state)
            FILL1: begin
              state <= FILL2;
            end
            default: begin
              // A produce overrides the consume clear above, keeping out_val high.
              out_grad <= $signed(grad);
              out_val  <= 1'b1;
`ifdef GRADIENT_CELL_COLIDX_EN
              // Saturated count minus one tops out at MAX_COLS-2.
              out_col  <= cnt_inc - CNT_W'(1);
`endif
              state    <= RUN;
            end
          endcase
        end
      end
    end
  end

endmodule
